// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type, default width and counter sizing for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int DIV_W_DEF = 32;

    function automatic int div_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift {r,q} left, trial-subtract d, keep on no borrow
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_nxt,
    output logic [W-1:0] q_nxt
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // r < d holds between steps, so W+1 bits is enough for the trial result to carry a clean borrow bit
    assign shifted = {r, q[W-1]};
    assign trial   = shifted - {1'b0, d};
    assign r_nxt   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    assign q_nxt   = {q[W-2:0], ~trial[W]};

endmodule

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - radix-2 restoring divider, one quotient bit per clock; DIV_SIGNED_EN adds two's-complement mode
module div_seq_unit
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         div_by_zero
);

    localparam int CNT_W = div_cnt_w(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    div_state_t     state, state_nxt;
    logic [W-1:0]   q_reg, r_reg, d_reg;
    logic [W-1:0]   q_nxt, r_nxt;
    logic [W-1:0]   q_fin, r_fin;
    logic [W-1:0]   a_mag, b_mag;
    logic [CNT_W-1:0] cnt;
    logic           accept, zero_div;

    assign accept   = start && (state == DIV_IDLE);
    assign zero_div = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, q_neg, r_neg;

    assign a_neg = is_signed & dividend[W-1];
    assign b_neg = is_signed & divisor[W-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    // remainder follows the dividend's sign, quotient is negative when the operand signs differ
    assign q_fin = q_neg ? -q_nxt : q_nxt;
    assign r_fin = r_neg ? -r_nxt : r_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q_nxt;
    assign r_fin = r_nxt;
`endif

    div_step #(.W(W)) u_step (
        .r     (r_reg),
        .q     (q_reg),
        .d     (d_reg),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = zero_div ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == CNT_LAST) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    assign ready = (state == DIV_IDLE);
    assign done  = (state == DIV_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= DIV_IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                q_reg       <= a_mag;
                d_reg       <= b_mag;
                r_reg       <= '0;
                cnt         <= '0;
                div_by_zero <= zero_div;
                // a zero divisor skips the iterations, so its results are loaded straight away
                if (zero_div) begin
                    quot <= '1;
                    rem  <= dividend;
                end
            end else if (state == DIV_RUN) begin
                q_reg <= q_nxt;
                r_reg <= r_nxt;
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    quot <= q_fin;
                    rem  <= r_fin;
                end
            end
        end
    end

endmodule
